// File: rtl/cpu_pkg.sv
// Shared definitions for the eight-phase accumulator CPU and its display scanner:
// opcodes, phase indices, memory geometry and the 7-segment glyph table.
package cpu_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int MEM_W     = 8;

    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_STO  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;

    typedef enum logic [2:0] {
        PH_T0, PH_T1, PH_T2, PH_T3, PH_T4, PH_T5, PH_T6, PH_T7
    } phase_e;

    typedef struct packed {
        logic ld;
        logic add;
        logic sub;
        logic and_op;
        logic or_op;
        logic sto;
        logic halt;
    } strobes_t;

    localparam logic [MEM_W-1:0] MEM_INIT [MEM_DEPTH] = '{
        8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h5E, 8'h6F, 8'h70, 8'h00,
        8'h00, 8'h00, 8'h05, 8'h03, 8'h02, 8'h0F, 8'h30, 8'h00
    };

    // Active-low segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/cpu_top.sv
// Accumulator CPU: clk/4 step enable, eight-phase sequencer, datapath and the
// 16x8 unified program/data memory.
module cpu_top
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             RESET,
    output logic             cpu_clk,
    output logic [7:0]       t,
    output strobes_t         strobes,
    output logic [MEM_W-1:0] acc,
    output logic [MEM_W-1:0] alu
);

    logic [1:0]       div_q, div_d;
    phase_e           phase_q, phase_d;
    logic [3:0]       pc_q, pc_d, mar_q, mar_d;
    logic [MEM_W-1:0] ir_q, ir_d, mdr_q, mdr_d, acc_q, acc_d;
    logic             mem_we;
    logic             step;

    // NOTE: memory contents survive reset; they are only preloaded at configuration.
    logic [MEM_W-1:0] mem_q [MEM_DEPTH] = MEM_INIT;

    // cpu_clk rises as div_q goes 1->2; that same clk edge is the CPU step.
    assign cpu_clk = div_q[1];
    assign step    = (div_q == 2'd1);
    assign t       = 8'b1 << phase_q;
    assign acc     = acc_q;

    always_comb begin
        strobes = '0;
        case (ir_q[7:4])
            OP_LD:   strobes.ld     = 1'b1;
            OP_ADD:  strobes.add    = 1'b1;
            OP_SUB:  strobes.sub    = 1'b1;
            OP_AND:  strobes.and_op = 1'b1;
            OP_OR:   strobes.or_op  = 1'b1;
            OP_STO:  strobes.sto    = 1'b1;
            OP_HALT: strobes.halt   = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        alu = acc_q;
        if (strobes.ld)     alu = mdr_q;
        if (strobes.add)    alu = acc_q + mdr_q;
        if (strobes.sub)    alu = acc_q - mdr_q;
        if (strobes.and_op) alu = acc_q & mdr_q;
        if (strobes.or_op)  alu = acc_q | mdr_q;
    end

    // NOTE: every next-state signal gets its hold value first so no latch is inferred.
    always_comb begin
        div_d   = div_q + 2'd1;
        phase_d = phase_q;
        pc_d    = pc_q;
        mar_d   = mar_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        acc_d   = acc_q;
        mem_we  = 1'b0;
        if (step) begin
            if (RESET) begin
                phase_d = PH_T0;
                pc_d    = '0;
                mar_d   = '0;
                ir_d    = '0;
                mdr_d   = '0;
                acc_d   = '0;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
                unique case (phase_q)
                    PH_T0: mar_d = pc_q;
                    PH_T1: begin
                        mdr_d = mem_q[mar_q];
                        pc_d  = pc_q + 4'd1;
                    end
                    PH_T2: ir_d = mdr_q;
                    PH_T3: if (strobes.halt) phase_d = PH_T3;
                    PH_T4: mar_d = ir_q[3:0];
                    PH_T5: mdr_d = mem_q[mar_q];
                    PH_T6: mem_we = strobes.sto;
                    PH_T7: acc_d = alu;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            phase_q <= PH_T0;
            pc_q    <= '0;
            mar_q   <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            acc_q   <= '0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mar_q] <= acc_q;
    end

endmodule

// File: rtl/seg_7.sv
// Four-digit multiplexed hex scanner: ALU low/high nibble, then ACC low/high nibble,
// each digit lit for 2^SCAN_DIV clk cycles.
module seg_7
    import cpu_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MEM_W-1:0] mem,
    input  logic [MEM_W-1:0] data,
    output logic [7:0]       an,
    output logic [6:0]       seg7
);

    localparam int CNT_W = SCAN_DIV + 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit;
    logic [3:0]       nibble;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        digit  = cnt_q[CNT_W-1:SCAN_DIV];
        nibble = data[3:0];
        case (digit)
            2'd0: nibble = data[3:0];
            2'd1: nibble = data[7:4];
            2'd2: nibble = mem[3:0];
            2'd3: nibble = mem[7:4];
        endcase
        an   = {4'hF, ~(4'b0001 << digit)};
        seg7 = hex_glyph(nibble);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cpu_system_top.sv
// Board-level wrapper: accumulator CPU plus the hex display scanner showing ALU and ACC.
module cpu_system_top
    import cpu_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RESET,
    output logic             cpu_clk,
    output logic             T0,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic             T4,
    output logic             T5,
    output logic             T6,
    output logic             T7,
    output logic             LD,
    output logic             ADD,
    output logic             SUB,
    output logic             AND,
    output logic             OR,
    output logic             STO,
    output logic             HALT,
    output logic [MEM_W-1:0] acc,
    output logic [MEM_W-1:0] alu,
    output logic [7:0]       an,
    output logic [6:0]       seg7
);

    logic [7:0] t;
    strobes_t   strobes;

    cpu_top u_cpu (
        .clk     (clk),
        .reset   (reset),
        .RESET   (RESET),
        .cpu_clk (cpu_clk),
        .t       (t),
        .strobes (strobes),
        .acc     (acc),
        .alu     (alu)
    );

    seg_7 #(.SCAN_DIV(SCAN_DIV)) u_seg (
        .clk   (clk),
        .reset (reset),
        .mem   (acc),
        .data  (alu),
        .an    (an),
        .seg7  (seg7)
    );

    assign {T7, T6, T5, T4, T3, T2, T1, T0}        = t;
    assign {LD, ADD, SUB, AND, OR, STO, HALT} = strobes;

endmodule

// File: tb/tb_cpu_system_top.sv
// Self-checking bench for cpu_system_top: cycle-level model of the CPU and scanner
// compared every clk cycle, plus hand-computed checkpoints of the default program.
module tb_cpu_system_top;

    localparam int SCAN_DIV = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       RESET = 1'b0;
    logic       cpu_clk;
    logic       T0, T1, T2, T3, T4, T5, T6, T7;
    logic       LD, ADD, SUB, AND, OR, STO, HALT;
    logic [7:0] acc, alu, an;
    logic [6:0] seg7;

    cpu_system_top #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset(reset), .RESET(RESET), .cpu_clk(cpu_clk),
        .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6), .T7(T7),
        .LD(LD), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .STO(STO), .HALT(HALT),
        .acc(acc), .alu(alu), .an(an), .seg7(seg7)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] prog_img [16] = '{8'h1A, 8'h2B, 8'h3C, 8'h4D, 8'h5E, 8'h6F, 8'h70, 8'h00,
                                  8'h00, 8'h00, 8'h05, 8'h03, 8'h02, 8'h0F, 8'h30, 8'h00};
    logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int         m_cyc;    // clk edges since reset release (not cleared by RESET)
    int         m_phase;
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_mdr, m_acc;
    logic [7:0] m_mem [16];
    logic       model_on = 1'b0;

    function automatic logic [7:0] alu_of(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] m);
        case (op)
            4'h1:    return m;
            4'h2:    return a + m;
            4'h3:    return a - m;
            4'h4:    return a & m;
            4'h5:    return a | m;
            default: return a;
        endcase
    endfunction

    task automatic clear_regs();
        m_phase = 0;
        m_pc    = '0;
        m_mar   = '0;
        m_ir    = '0;
        m_mdr   = '0;
        m_acc   = '0;
    endtask

    task automatic model_step();
        if (RESET) begin
            clear_regs();
        end else begin
            case (m_phase)
                0: m_mar = m_pc;
                1: begin m_mdr = m_mem[m_mar]; m_pc = m_pc + 4'd1; end
                2: m_ir = m_mdr;
                4: m_mar = m_ir[3:0];
                5: m_mdr = m_mem[m_mar];
                6: if (m_ir[7:4] == 4'h6) m_mem[m_mar] = m_acc;
                7: m_acc = alu_of(m_ir[7:4], m_acc, m_mdr);
                default: ;
            endcase
            if (!(m_phase == 3 && m_ir[7:4] == 4'h7)) m_phase = (m_phase + 1) % 8;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc = 0;
            clear_regs();
        end else begin
            m_cyc++;
            if (m_cyc % 4 == 2) model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (model_on) begin
            int         op;
            int         digit;
            logic [7:0] e_alu;
            logic [3:0] nib;
            logic [6:0] e_str;
            op    = int'(m_ir[7:4]);
            e_alu = alu_of(m_ir[7:4], m_acc, m_mdr);
            e_str = (op >= 1 && op <= 7) ? 7'(7'h40 >> (op - 1)) : 7'h00;
            digit = (m_cyc >> SCAN_DIV) % 4;
            case (digit)
                0:       nib = e_alu[3:0];
                1:       nib = e_alu[7:4];
                2:       nib = m_acc[3:0];
                default: nib = m_acc[7:4];
            endcase
            check("cyc_cpu_clk", cpu_clk, (m_cyc % 4) >= 2);
            check("cyc_phase", {T7, T6, T5, T4, T3, T2, T1, T0}, 8'h01 << m_phase);
            check("cyc_strobes", {LD, ADD, SUB, AND, OR, STO, HALT}, e_str);
            check("cyc_acc", acc, m_acc);
            check("cyc_alu", alu, e_alu);
            check("cyc_an", an, 8'hFF & ~(8'h01 << digit));
            check("cyc_seg7", seg7, glyph_tbl[nib]);
        end
    end

    // ---------------- directed sequence ----------------
    task automatic run_to(input int n);
        while (m_cyc < n) @(negedge clk);
    endtask

    logic [7:0] acc_lit [5] = '{8'h05, 8'h08, 8'h06, 8'h06, 8'h36};
    logic [7:0] an_lit  [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    logic [6:0] seg_lit [4] = '{7'b0000010, 7'b0110000, 7'b0000010, 7'b0110000};

    initial begin
        int k;
        for (int i = 0; i < 16; i++) m_mem[i] = prog_img[i];
        m_cyc = 0;
        clear_regs();
        model_on = 1'b1;

        #200;
        check("rst_T0", T0, 1'b1);
        check("rst_acc", acc, 8'h00);
        check("rst_alu", alu, 8'h00);
        check("rst_strobes", {LD, ADD, SUB, AND, OR, STO, HALT}, 7'h00);
        check("rst_an", an, 8'hFE);
        check("rst_seg7", seg7, 7'b1000000);
        check("rst_cpu_clk", cpu_clk, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        run_to(1);
        check("first_cpu_clk_low", cpu_clk, 1'b0);
        run_to(2);
        check("first_cpu_clk_high", cpu_clk, 1'b1);
        check("first_T1", T1, 1'b1);
        run_to(10);
        check("first_T3", T3, 1'b1);
        check("first_LD", LD, 1'b1);
        for (int i = 0; i < 5; i++) begin
            run_to(30 + 32 * i);
            check("instr_acc", acc, acc_lit[i]);
            check("instr_T0", T0, 1'b1);
        end
        run_to(187);
        check("sto_memF", dut.u_cpu.mem_q[15], 8'h36);
        run_to(300);
        check("halt_T3", T3, 1'b1);
        check("halt_HALT", HALT, 1'b1);
        check("halt_acc", acc, 8'h36);
        check("halt_alu", alu, 8'h36);

        for (int d = 0; d < 4; d++) begin
            k = 0;
            while (an !== an_lit[d] && k < 80) begin @(negedge clk); k++; end
            check("disp_an_seen", k < 80, 1'b1);
            check("disp_seg7", seg7, seg_lit[d]);
        end

        // Synchronous restart while halted.
        @(negedge clk);
        RESET = 1'b1;
        repeat (4) @(negedge clk);
        RESET = 1'b0;
        check("restart_T0", T0, 1'b1);
        check("restart_acc", acc, 8'h00);
        check("restart_pc", dut.u_cpu.pc_q, 4'h0);
        k = 0;
        while (T7 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        check("restart_T7_seen", k < 40, 1'b1);
        k = 0;
        while (T0 !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        check("restart_T0_seen", k < 10, 1'b1);
        check("restart_acc_ld", acc, 8'h05);

        // Asynchronous reset in the middle of an instruction.
        repeat (13) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_T0", T0, 1'b1);
        check("async_acc", acc, 8'h00);
        check("async_cpu_clk", cpu_clk, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        k = 0;
        while (HALT !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        check("rerun_halt_seen", k < 400, 1'b1);
        check("rerun_acc", acc, 8'h36);
        check("rerun_memF", dut.u_cpu.mem_q[15], 8'h36);
        repeat (40) @(negedge clk);
        check("rerun_T3_held", T3, 1'b1);
        check("rerun_acc_held", acc, 8'h36);

        model_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
